alu_issue_ctrl: RTL and testbench

//  Request-side front end for the 32-bit combinational ALU. Accepts decoded-instruction requests (opcode, funct, operands) on a valid/ready handshake.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_op_decoder.sv | 67 ++++++
 rtl/alu_issue_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue front end: ALU operation codes, MIPS
// opcode/funct field values and the issue-controller FSM state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU operation codes as understood by the combinational ALU
   localparam logic [3:0] ALU_AND  = 4'h0;
   localparam logic [3:0] ALU_OR   = 4'h1;
   localparam logic [3:0] ALU_NOR  = 4'h2;
   localparam logic [3:0] ALU_ADD  = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h4;
   localparam logic [3:0] ALU_IDLE = 4'hF;

   // Opcode field values
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;

   // Funct field values (R-type only)
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // Issue controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

endpackage : alu_pkg

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Combinational translation of a MIPS opcode/funct pair into the ALU operation
// code plus the post-processing flags needed by the issue controller.
// Ports:
//   opcode   in  6  MIPS opcode field
//   funct    in  6  MIPS funct field, only looked at for R-type
//   alu_op   out 4  ALU operation (ALU_IDLE for illegal encodings)
//   is_slt   out 1  result must be reduced to a signed less-than bit
//   is_beq   out 1  branch taken when the subtraction is zero
//   is_bne   out 1  branch taken when the subtraction is non-zero
//   illegal  out 1  opcode/funct not supported
// -----------------------------------------------------------------------------
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       is_slt,
   output logic       is_beq,
   output logic       is_bne,
   output logic       illegal
);

   // Decode opcode (and funct for R-type) into operation and flags
   always_comb begin
      alu_op  = ALU_IDLE;
      is_slt  = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            case (funct)
               FN_ADD, FN_ADDU: alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: alu_op = ALU_SUB;
               FN_AND:          alu_op = ALU_AND;
               FN_OR:           alu_op = ALU_OR;
               FN_NOR:          alu_op = ALU_NOR;
               FN_SLT: begin
                  alu_op = ALU_SUB;
                  is_slt = 1'b1;
               end
               default:         illegal = 1'b1;
            endcase
         end
         OPC_ADDI, OPC_ADDIU: alu_op = ALU_ADD;
         OPC_ANDI:            alu_op = ALU_AND;
         OPC_ORI:             alu_op = ALU_OR;
         OPC_SLTI: begin
            alu_op = ALU_SUB;
            is_slt = 1'b1;
         end
         OPC_BEQ: begin
            alu_op = ALU_SUB;
            is_beq = 1'b1;
         end
         OPC_BNE: begin
            alu_op = ALU_SUB;
            is_bne = 1'b1;
         end
         default:             illegal = 1'b1;
      endcase
   end

endmodule : alu_op_decoder

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Request-side front end for the 32-bit combinational ALU. A request is taken
// on a valid/ready handshake, decoded into an ALU operation, presented to the
// ALU from registers for a full settle cycle, and the ALU result is captured,
// post-processed (SLT/SLTI, BEQ/BNE) and returned on a valid/ready response.
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_opcode/req_funct       MIPS opcode / funct fields
//   req_a/req_b                operands
//   ALUOperation/ALU_A/ALU_B   registered drive into the ALU
//   ALUResult/Zero             ALU outputs
//   resp_valid/resp_ready      response handshake
//   resp_result/resp_zero      final result and its zero flag
//   resp_branch_taken          BEQ/BNE outcome
//   resp_illegal               unsupported opcode/funct
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [5:0]        req_opcode,
   input  logic [5:0]        req_funct,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [3:0]        ALUOperation,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic              Zero,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_result,
   output logic              resp_zero,
   output logic              resp_branch_taken,
   output logic              resp_illegal
);

   // Signed less-than from a subtraction: the sign bit lies when a-b overflows
   function automatic logic slt_bit(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic [DATA_W-1:0] res);
      logic ovf;
      ovf = (a[DATA_W-1] != b[DATA_W-1]) & (res[DATA_W-1] != a[DATA_W-1]);
      return res[DATA_W-1] ^ ovf;
   endfunction

   state_e            state_q, state_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic              is_slt_q, is_slt_d;
   logic              is_beq_q, is_beq_d;
   logic              is_bne_q, is_bne_d;
   logic              illegal_q, illegal_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_result_q, resp_result_d;
   logic              resp_zero_q, resp_zero_d;
   logic              resp_branch_q, resp_branch_d;
   logic              resp_illegal_q, resp_illegal_d;

   logic [3:0]        dec_op_s;
   logic              dec_slt_s;
   logic              dec_beq_s;
   logic              dec_bne_s;
   logic              dec_illegal_s;
   logic              slt_s;

   alu_op_decoder u_dec (
      .opcode  (req_opcode),
      .funct   (req_funct),
      .alu_op  (dec_op_s),
      .is_slt  (dec_slt_s),
      .is_beq  (dec_beq_s),
      .is_bne  (dec_bne_s),
      .illegal (dec_illegal_s)
   );

   assign slt_s = slt_bit(alu_a_q, alu_b_q, ALUResult);

   // Next-state, operand/op register and response register computation
   always_comb begin
      state_d        = state_q;
      alu_op_d       = alu_op_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      is_slt_d       = is_slt_q;
      is_beq_d       = is_beq_q;
      is_bne_d       = is_bne_q;
      illegal_d      = illegal_q;
      resp_valid_d   = resp_valid_q;
      resp_result_d  = resp_result_q;
      resp_zero_d    = resp_zero_q;
      resp_branch_d  = resp_branch_q;
      resp_illegal_d = resp_illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d   = ST_ISSUE;
               alu_op_d  = dec_op_s;
               alu_a_d   = req_a;
               alu_b_d   = req_b;
               is_slt_d  = dec_slt_s;
               is_beq_d  = dec_beq_s;
               is_bne_d  = dec_bne_s;
               illegal_d = dec_illegal_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // ALU inputs held unchanged so the combinational path settles
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            // ALU inputs stay valid through this cycle, then park the ALU
            alu_op_d     = ALU_IDLE;
            alu_a_d      = '0;
            alu_b_d      = '0;
            if (illegal_q) begin
               resp_result_d  = '0;
               resp_zero_d    = 1'b1;
               resp_branch_d  = 1'b0;
               resp_illegal_d = 1'b1;
            end else if (is_slt_q) begin
               resp_result_d  = {{(DATA_W-1){1'b0}}, slt_s};
               resp_zero_d    = ~slt_s;
               resp_branch_d  = 1'b0;
               resp_illegal_d = 1'b0;
            end else begin
               resp_result_d  = ALUResult;
               resp_zero_d    = (ALUResult == '0);
               resp_branch_d  = (is_beq_q & Zero) | (is_bne_q & ~Zero);
               resp_illegal_d = 1'b0;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d        = ST_IDLE;
               resp_valid_d   = 1'b0;
               resp_result_d  = '0;
               resp_zero_d    = 1'b0;
               resp_branch_d  = 1'b0;
               resp_illegal_d = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d        = ST_IDLE;
            alu_op_d       = ALU_IDLE;
            alu_a_d        = '0;
            alu_b_d        = '0;
            resp_valid_d   = 1'b0;
            resp_result_d  = '0;
            resp_zero_d    = 1'b0;
            resp_branch_d  = 1'b0;
            resp_illegal_d = 1'b0;
         end
      endcase
   end

   // State, ALU drive and response registers; reset drops any in-flight op
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         alu_op_q       <= ALU_IDLE;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         is_slt_q       <= 1'b0;
         is_beq_q       <= 1'b0;
         is_bne_q       <= 1'b0;
         illegal_q      <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_result_q  <= '0;
         resp_zero_q    <= 1'b0;
         resp_branch_q  <= 1'b0;
         resp_illegal_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         alu_op_q       <= alu_op_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         is_slt_q       <= is_slt_d;
         is_beq_q       <= is_beq_d;
         is_bne_q       <= is_bne_d;
         illegal_q      <= illegal_d;
         resp_valid_q   <= resp_valid_d;
         resp_result_q  <= resp_result_d;
         resp_zero_q    <= resp_zero_d;
         resp_branch_q  <= resp_branch_d;
         resp_illegal_q <= resp_illegal_d;
      end
   end

   assign req_ready         = (state_q == ST_IDLE);
   assign ALUOperation      = alu_op_q;
   assign ALU_A             = alu_a_q;
   assign ALU_B             = alu_b_q;
   assign resp_valid        = resp_valid_q;
   assign resp_result       = resp_result_q;
   assign resp_zero         = resp_zero_q;
   assign resp_branch_taken = resp_branch_q;
   assign resp_illegal      = resp_illegal_q;

endmodule : alu_issue_ctrl

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_opcode;
   logic [5:0]  req_funct;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  ALUOperation;
   logic [31:0] ALU_A;
   logic [31:0] ALU_B;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_zero;
   logic        resp_branch_taken;
   logic        resp_illegal;

   int errors = 0;
   int checks = 0;

   alu_issue_ctrl #(.DATA_W(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_opcode        (req_opcode),
      .req_funct         (req_funct),
      .req_a             (req_a),
      .req_b             (req_b),
      .ALUOperation      (ALUOperation),
      .ALU_A             (ALU_A),
      .ALU_B             (ALU_B),
      .ALUResult         (ALUResult),
      .Zero              (Zero),
      .resp_valid        (resp_valid),
      .resp_ready        (resp_ready),
      .resp_result       (resp_result),
      .resp_zero         (resp_zero),
      .resp_branch_taken (resp_branch_taken),
      .resp_illegal      (resp_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural combinational ALU driven by the DUT
   always_comb begin
      case (ALUOperation)
         4'h0:    ALUResult = ALU_A & ALU_B;
         4'h1:    ALUResult = ALU_A | ALU_B;
         4'h2:    ALUResult = ~(ALU_A | ALU_B);
         4'h3:    ALUResult = ALU_A + ALU_B;
         4'h4:    ALUResult = ALU_A - ALU_B;
         default: ALUResult = 32'h0;
      endcase
   end
   assign Zero = (ALUResult == 32'h0);

   // Present a request and return #1 after the edge that accepted it
   task automatic do_accept(input logic [5:0] opc, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
      end
      req_opcode = opc; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_opcode = 6'h00; req_funct = 6'h00; req_a = 32'h0; req_b = 32'h0;
   endtask

   // Wait (bounded) for resp_valid
   task automatic wait_resp(input string name);
      int n;
      n = 0;
      while (resp_valid !== 1'b1 && n < 10) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: resp_valid=%b required 1", name, resp_valid);
      end
   endtask

   // Complete the response handshake
   task automatic handshake();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (ALUOperation !== 4'hF || ALU_A !== 32'h0 || ALU_B !== 32'h0) begin
         errors++;
         $display("FAIL reset_alu: op=%h a=%h b=%h required F 0 0", ALUOperation, ALU_A, ALU_B);
      end
      checks++;
      if ({resp_valid, resp_result, resp_zero, resp_branch_taken, resp_illegal} !== 36'h0) begin
         errors++;
         $display("FAIL reset_resp: valid=%b result=%h zero=%b br=%b ill=%b required all 0",
                  resp_valid, resp_result, resp_zero, resp_branch_taken, resp_illegal);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_add_latency();
      do_accept(6'h00, 6'h20, 32'd7, 32'd5);
      checks++;
      if (ALUOperation !== 4'h3 || ALU_A !== 32'd7 || ALU_B !== 32'd5 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL add_issue: op=%h a=%h b=%h ready=%b required 3 7 5 0",
                  ALUOperation, ALU_A, ALU_B, req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_early: resp_valid=%b required 0 one edge after accept", resp_valid);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'd12 || resp_zero !== 1'b0 ||
          resp_branch_taken !== 1'b0 || resp_illegal !== 1'b0) begin
         errors++;
         $display("FAIL add_resp: valid=%b result=%h zero=%b br=%b ill=%b required 1 0000000c 0 0 0",
                  resp_valid, resp_result, resp_zero, resp_branch_taken, resp_illegal);
      end
      checks++;
      if (ALUOperation !== 4'hF || ALU_A !== 32'h0 || ALU_B !== 32'h0) begin
         errors++;
         $display("FAIL add_park: op=%h a=%h b=%h required F 0 0", ALUOperation, ALU_A, ALU_B);
      end
      handshake();
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_done: resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
      end
   endtask

   // Table of plain ops: opcode, funct, a, b, expected result
   task automatic test_ops();
      logic [5:0]  opc [8];
      logic [5:0]  fn  [8];
      logic [31:0] va  [8];
      logic [31:0] vb  [8];
      logic [31:0] exp [8];
      opc[0] = 6'h00; fn[0] = 6'h22; va[0] = 32'd10;         vb[0] = 32'd3;          exp[0] = 32'd7;
      opc[1] = 6'h00; fn[1] = 6'h24; va[1] = 32'h0F0F_0000;  vb[1] = 32'h00FF_00FF;  exp[1] = 32'h000F_0000;
      opc[2] = 6'h00; fn[2] = 6'h25; va[2] = 32'h0F0F_0000;  vb[2] = 32'h00FF_00FF;  exp[2] = 32'h0FFF_00FF;
      opc[3] = 6'h00; fn[3] = 6'h27; va[3] = 32'h0F0F_0000;  vb[3] = 32'h00FF_00FF;  exp[3] = 32'hF000_FF00;
      opc[4] = 6'h0C; fn[4] = 6'h3F; va[4] = 32'hFFFF_1234;  vb[4] = 32'h0000_FFFF;  exp[4] = 32'h0000_1234;
      opc[5] = 6'h0D; fn[5] = 6'h00; va[5] = 32'h1200_0000;  vb[5] = 32'h0000_0034;  exp[5] = 32'h1200_0034;
      opc[6] = 6'h0A; fn[6] = 6'h00; va[6] = 32'hFFFF_FFFB;  vb[6] = 32'd3;          exp[6] = 32'd1;
      opc[7] = 6'h00; fn[7] = 6'h23; va[7] = 32'd0;          vb[7] = 32'd1;          exp[7] = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
         do_accept(opc[i], fn[i], va[i], vb[i]);
         wait_resp("ops");
         checks++;
         if (resp_result !== exp[i] || resp_zero !== (exp[i] == 32'h0) || resp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL ops[%0d]: result=%h zero=%b ill=%b required %h %b 0",
                     i, resp_result, resp_zero, resp_illegal, exp[i], (exp[i] == 32'h0));
         end
         handshake();
      end
   endtask

   task automatic test_slt_overflow();
      do_accept(6'h00, 6'h2A, 32'h8000_0000, 32'd1);
      wait_resp("slt_ovf");
      checks++;
      if (resp_result !== 32'd1 || resp_zero !== 1'b0) begin
         errors++;
         $display("FAIL slt_ovf: result=%h zero=%b required 00000001 0", resp_result, resp_zero);
      end
      handshake();
      do_accept(6'h00, 6'h2A, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      wait_resp("slt_rev");
      checks++;
      if (resp_result !== 32'd0 || resp_zero !== 1'b1) begin
         errors++;
         $display("FAIL slt_rev: result=%h zero=%b required 00000000 1", resp_result, resp_zero);
      end
      handshake();
   endtask

   task automatic test_branches();
      do_accept(6'h04, 6'h00, 32'h0000_DEAD, 32'h0000_DEAD);
      wait_resp("beq");
      checks++;
      if (resp_branch_taken !== 1'b1 || resp_zero !== 1'b1 || resp_result !== 32'h0) begin
         errors++;
         $display("FAIL beq_equal: br=%b zero=%b result=%h required 1 1 0", resp_branch_taken, resp_zero, resp_result);
      end
      handshake();
      do_accept(6'h05, 6'h00, 32'h0000_DEAD, 32'h0000_DEAD);
      wait_resp("bne");
      checks++;
      if (resp_branch_taken !== 1'b0 || resp_zero !== 1'b1) begin
         errors++;
         $display("FAIL bne_equal: br=%b zero=%b required 0 1", resp_branch_taken, resp_zero);
      end
      handshake();
      do_accept(6'h05, 6'h00, 32'd1, 32'd2);
      wait_resp("bne_diff");
      checks++;
      if (resp_branch_taken !== 1'b1 || resp_zero !== 1'b0 || resp_result !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL bne_diff: br=%b zero=%b result=%h required 1 0 ffffffff", resp_branch_taken, resp_zero, resp_result);
      end
      handshake();
   endtask

   task automatic test_illegal_backpressure();
      logic [31:0] held;
      do_accept(6'h3F, 6'h00, 32'h1234_5678, 32'h9ABC_DEF0);
      checks++;
      if (ALUOperation !== 4'hF) begin
         errors++;
         $display("FAIL ill_issue_op: op=%h required F", ALUOperation);
      end
      @(posedge clk); #1;
      checks++;
      if (ALUOperation !== 4'hF) begin
         errors++;
         $display("FAIL ill_capture_op: op=%h required F", ALUOperation);
      end
      wait_resp("illegal");
      checks++;
      if (resp_illegal !== 1'b1 || resp_result !== 32'h0 || resp_zero !== 1'b1 || resp_branch_taken !== 1'b0) begin
         errors++;
         $display("FAIL ill_resp: ill=%b result=%h zero=%b br=%b required 1 0 1 0",
                  resp_illegal, resp_result, resp_zero, resp_branch_taken);
      end
      held = resp_result;
      req_opcode = 6'h00; req_funct = 6'h20; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_illegal !== 1'b1 || resp_result !== held ||
             req_ready !== 1'b0 || ALUOperation !== 4'hF) begin
            errors++;
            $display("FAIL ill_hold[%0d]: valid=%b ill=%b result=%h ready=%b op=%h required 1 1 %h 0 F",
                     i, resp_valid, resp_illegal, resp_result, req_ready, ALUOperation, held);
         end
      end
      req_valid = 1'b0;
      handshake();
   endtask

   task automatic test_wrap();
      do_accept(6'h08, 6'h00, 32'hFFFF_FFFF, 32'd1);
      wait_resp("wrap");
      checks++;
      if (resp_result !== 32'h0 || resp_zero !== 1'b1 || resp_illegal !== 1'b0) begin
         errors++;
         $display("FAIL addi_wrap: result=%h zero=%b ill=%b required 0 1 0", resp_result, resp_zero, resp_illegal);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      resp_ready = 1'b1;
      do_accept(6'h09, 6'h00, 32'd100, 32'd23);
      wait_resp("b2b0");
      checks++;
      if (resp_result !== 32'd123) begin
         errors++;
         $display("FAIL b2b_first: result=%h required 0000007b", resp_result);
      end
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_return: ready=%b valid=%b required 1 0", req_ready, resp_valid);
      end
      do_accept(6'h00, 6'h21, 32'd40, 32'd2);
      wait_resp("b2b1");
      checks++;
      if (resp_result !== 32'd42) begin
         errors++;
         $display("FAIL b2b_second: result=%h required 0000002a", resp_result);
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      do_accept(6'h00, 6'h20, 32'd3, 32'd4);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (ALUOperation !== 4'hF || ALU_A !== 32'h0 || ALU_B !== 32'h0 ||
          resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: op=%h a=%h b=%h valid=%b ready=%b required F 0 0 0 1",
                  ALUOperation, ALU_A, ALU_B, resp_valid, req_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_drop: resp_valid=%b required 0", resp_valid);
      end
      do_accept(6'h00, 6'h25, 32'h0000_00F0, 32'h0000_000F);
      wait_resp("post_reset");
      checks++;
      if (resp_result !== 32'h0000_00FF || resp_zero !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_or: result=%h zero=%b required 000000ff 0", resp_result, resp_zero);
      end
      handshake();
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0; req_opcode = 6'h00; req_funct = 6'h00;
      req_a = 32'h0; req_b = 32'h0; resp_ready = 1'b0;
      #12;
      test_reset();
      test_add_latency();
      test_ops();
      test_slt_overflow();
      test_branches();
      test_illegal_backpressure();
      test_wrap();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_issue_ctrl
